fc_stack_ctrl: RTL and testbench

FC_STACK_CTRL -- requirements
Module: fc_stack_ctrl

---
 rtl/fc_ctrl_pkg.sv | 22 ++
 rtl/fc_frame_mux.sv | 33 +++
 rtl/fc_stack_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fc_stack_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// Shared definitions for the frame-context stack controller.
// Holds the controller state encoding and the frame geometry:
// a frame is FRAME_WORDS words of WORD_W bits, FC_W bits in total,
// with word k living at bits [16k+15:16k] of the flat frame vector.
package fc_ctrl_pkg;

  localparam int FRAME_WORDS = 15;
  localparam int WORD_W      = 16;
  localparam int FC_W        = FRAME_WORDS * WORD_W;
  localparam int BEAT_W      = 4;

  // Index of the final beat of a frame transfer.
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    LOAD  = 2'd2,
    APPLY = 2'd3
  } fcState_e;

endpackage

// File: rtl/fc_frame_mux.sv
// Word access into a flat 240-bit frame vector.
// Ports:
//   selFrame_i  frame to read from (the saved snapshot)
//   beat_i      word index 0..14
//   selWord_o   word beat_i of selFrame_i
//   insFrame_i  frame to modify (the restore buffer)
//   insWord_i   word to place at index beat_i
//   insFrame_o  insFrame_i with word beat_i replaced by insWord_i
module fc_frame_mux
  import fc_ctrl_pkg::*;
(
  input  logic [FC_W-1:0]   selFrame_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [WORD_W-1:0] selWord_o,
  input  logic [FC_W-1:0]   insFrame_i,
  input  logic [WORD_W-1:0] insWord_i,
  output logic [FC_W-1:0]   insFrame_o
);

  // Constant-index loops keep every part select inside the 240-bit
  // vector; beat index 15 simply selects nothing and inserts nothing.
  always_comb begin
    selWord_o  = '0;
    insFrame_o = insFrame_i;
    for (int k = 0; k < FRAME_WORDS; k++) begin
      if (beat_i == BEAT_W'(k)) begin
        selWord_o                      = selFrame_i[k*WORD_W +: WORD_W];
        insFrame_o[k*WORD_W +: WORD_W] = insWord_i;
      end
    end
  end

endmodule

// File: rtl/fc_stack_ctrl.sv
// Frame-context stack controller.
// Saves the 15-word register-file frame context to a memory stack on a
// call and restores the most recent frame on a return, one word per
// memory handshake beat.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   callReq, retReq       save / restore requests (honoured in IDLE only)
//   fcOut                 frame context from the register file
//   fcIn, restore         restored frame and its one-cycle load strobe
//   memAddr, memWData     stack memory word address / write data
//   memWe, memRe          write / read request, held until memAck
//   memRData, memAck      read data, beat completion
//   busy, done, err       in progress / completion pulse / rejection pulse
//   sp                    next free stack word address
module fc_stack_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter logic [15:0] STACK_BASE = 16'hF000,
  parameter int          MAX_FRAMES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            callReq,
  input  logic            retReq,
  input  logic [FC_W-1:0] fcOut,
  output logic [FC_W-1:0] fcIn,
  output logic            restore,
  output logic [15:0]     memAddr,
  output logic [15:0]     memWData,
  input  logic [15:0]     memRData,
  output logic            memWe,
  output logic            memRe,
  input  logic            memAck,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [15:0]     sp
);

  localparam int CNT_W = $clog2(MAX_FRAMES + 1);

  // A full stack must still fit below the top of the 16-bit address space.
  if (int'(STACK_BASE) + FRAME_WORDS * MAX_FRAMES > 32'h0000_FFFF) begin : g_badStackSize
    $error("fc_stack_ctrl: STACK_BASE + 15*MAX_FRAMES exceeds 16'hFFFF");
  end

  fcState_e          state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [15:0]       sp_q, sp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FC_W-1:0]   snap_q, snap_d;
  logic [FC_W-1:0]   fcIn_q, fcIn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [WORD_W-1:0] snapWord;
  logic [FC_W-1:0]   fcInIns;

  fc_frame_mux u_frameMux (
    .selFrame_i (snap_q),
    .beat_i     (beat_q),
    .selWord_o  (snapWord),
    .insFrame_i (fcIn_q),
    .insWord_i  (memRData),
    .insFrame_o (fcInIns)
  );

  // State register; reset abandons any beat in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      sp_q    <= STACK_BASE;
      count_q <= '0;
      snap_q  <= '0;
      fcIn_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      snap_q  <= snap_d;
      fcIn_q  <= fcIn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and memory-side outputs. done/err are registered so they
  // appear in the cycle after the deciding edge; for a return this puts
  // done in the same cycle as APPLY/restore.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    sp_d     = sp_q;
    count_d  = count_q;
    snap_d   = snap_q;
    fcIn_d   = fcIn_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    memWe    = 1'b0;
    memRe    = 1'b0;
    memAddr  = '0;
    memWData = '0;

    unique case (state_q)
      IDLE: begin
        if (callReq) begin
          if (count_q == CNT_W'(MAX_FRAMES)) begin
            err_d = 1'b1;
          end else begin
            snap_d  = fcOut;
            beat_d  = '0;
            state_d = SAVE;
          end
        end else if (retReq) begin
          if (count_q == '0) begin
            err_d = 1'b1;
          end else begin
            beat_d  = '0;
            state_d = LOAD;
          end
        end
      end

      SAVE: begin
        memWe    = 1'b1;
        memAddr  = sp_q + 16'(beat_q);
        memWData = snapWord;
        if (memAck) begin
          if (beat_q == LAST_BEAT) begin
            sp_d    = sp_q + 16'(FRAME_WORDS);
            count_d = count_q + CNT_W'(1);
            beat_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      LOAD: begin
        memRe   = 1'b1;
        memAddr = sp_q - 16'(FRAME_WORDS) + 16'(beat_q);
        if (memAck) begin
          fcIn_d = fcInIns;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            done_d  = 1'b1;
            state_d = APPLY;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      APPLY: begin
        sp_d    = sp_q - 16'(FRAME_WORDS);
        count_d = count_q - CNT_W'(1);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign fcIn    = fcIn_q;
  assign restore = (state_q == APPLY);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign sp      = sp_q;

endmodule

// File: tb/tb_fc_stack_ctrl.sv
// Directed self-checking bench for fc_stack_ctrl with a behavioural
// stack memory that can acknowledge every cycle or stall at random.
module tb_fc_stack_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         callReq;
  logic         retReq;
  logic [239:0] fcOut;
  logic [239:0] fcIn;
  logic         restore;
  logic [15:0]  memAddr;
  logic [15:0]  memWData;
  logic [15:0]  memRData;
  logic         memWe;
  logic         memRe;
  logic         memAck = 1'b1;
  logic         busy;
  logic         done;
  logic         err;
  logic [15:0]  sp;

  int errCount   = 0;
  int checkCount = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] wrAddrQ [$];
  logic [15:0] wrDataQ [$];
  logic [15:0] rdAddrQ [$];
  int          reCount   = 0;
  int          bothCount = 0;
  int          stallViol = 0;
  bit          stallMode = 1'b0;
  bit          holdPending = 1'b0;
  logic [15:0] holdAddr, holdData;

  fc_stack_ctrl #(
    .STACK_BASE (16'hF000),
    .MAX_FRAMES (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .callReq  (callReq),
    .retReq   (retReq),
    .fcOut    (fcOut),
    .fcIn     (fcIn),
    .restore  (restore),
    .memAddr  (memAddr),
    .memWData (memWData),
    .memRData (memRData),
    .memWe    (memWe),
    .memRe    (memRe),
    .memAck   (memAck),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .sp       (sp)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on an acked edge.
  assign memRData = mem[memAddr];

  always @(posedge clk) begin
    if (memWe && memAck) begin
      mem[memAddr] <= memWData;
      wrAddrQ.push_back(memAddr);
      wrDataQ.push_back(memWData);
    end
    if (memRe && memAck) rdAddrQ.push_back(memAddr);
    if (memRe) reCount++;
    if (memWe && memRe) bothCount++;
  end

  // Ack is changed just after the edge so it is stable at the next one.
  always @(posedge clk) begin
    #1;
    memAck = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // A stalled write must present identical address and data until acked.
  always @(negedge clk) begin
    if (holdPending && reset_n === 1'b1) begin
      if (memWe !== 1'b1 || memAddr !== holdAddr || memWData !== holdData)
        stallViol++;
    end
    holdPending = memWe && !memAck;
    holdAddr    = memAddr;
    holdData    = memWData;
  end

  function automatic logic [239:0] mkFrame(input int n);
    logic [239:0] f;
    for (int k = 0; k < 15; k++) f[16*k +: 16] = {8'(n), 8'(k + 1)};
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the request is accepted on the following edge.
  task automatic applyStimulus(input logic c, input logic r);
    callReq = c;
    retReq  = r;
    @(negedge clk);
    callReq = 1'b0;
    retReq  = 1'b0;
  endtask

  // Counts edges from the accept edge (edge 1) until done is seen.
  task automatic waitDone(input int budget, output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("doneSeen", 256'(done), 256'(1));
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int wrBefore;
    int rdBefore;
    logic [239:0] expFrame;

    reset_n = 1'b0;
    callReq = 1'b0;
    retReq  = 1'b0;
    fcOut   = '0;
    @(negedge clk);
    resetDut();

    $display("[TB] reset state");
    checkOutput("rstBusy",     256'(busy),     256'(0));
    checkOutput("rstDone",     256'(done),     256'(0));
    checkOutput("rstErr",      256'(err),      256'(0));
    checkOutput("rstRestore",  256'(restore),  256'(0));
    checkOutput("rstMemWe",    256'(memWe),    256'(0));
    checkOutput("rstMemRe",    256'(memRe),    256'(0));
    checkOutput("rstSp",       256'(sp),       256'(16'hF000));
    checkOutput("rstMemAddr",  256'(memAddr),  256'(0));
    checkOutput("rstMemWData", 256'(memWData), 256'(0));
    checkOutput("rstFcIn",     256'(fcIn),     256'(0));

    $display("[TB] single call, ack tied high");
    wrAddrQ.delete(); wrDataQ.delete();
    fcOut = mkFrame(0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("callBusy", 256'(busy), 256'(1));
    waitDone(40, cyc);
    checkOutput("callLatency", 256'(cyc), 256'(16));
    checkOutput("callNoRestore", 256'(restore), 256'(0));
    checkOutput("callSp", 256'(sp), 256'(16'hF00F));
    checkOutput("callWrCount", 256'(wrAddrQ.size()), 256'(15));
    for (int k = 0; k < 15 && k < wrAddrQ.size(); k++) begin
      checkOutput($sformatf("callWrAddr%0d", k), 256'(wrAddrQ[k]), 256'(16'hF000 + k));
      checkOutput($sformatf("callWrData%0d", k), 256'(wrDataQ[k]), 256'(k + 1));
    end
    @(negedge clk);
    checkOutput("callDonePulse", 256'(done), 256'(0));

    $display("[TB] single return");
    rdAddrQ.delete();
    fcOut = mkFrame(77);
    applyStimulus(1'b0, 1'b1);
    waitDone(40, cyc);
    checkOutput("retLatency", 256'(cyc), 256'(16));
    checkOutput("retRestore", 256'(restore), 256'(1));
    checkOutput("retFcIn", 256'(fcIn), 256'(mkFrame(0)));
    checkOutput("retRdCount", 256'(rdAddrQ.size()), 256'(15));
    for (int k = 0; k < 15 && k < rdAddrQ.size(); k++)
      checkOutput($sformatf("retRdAddr%0d", k), 256'(rdAddrQ[k]), 256'(16'hF000 + k));
    @(negedge clk);
    checkOutput("retSp", 256'(sp), 256'(16'hF000));
    checkOutput("retRestorePulse", 256'(restore), 256'(0));
    checkOutput("retDonePulse", 256'(done), 256'(0));
    checkOutput("retFcInHeld", 256'(fcIn), 256'(mkFrame(0)));

    $display("[TB] return on empty stack");
    resetDut();
    reCount = 0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("emptyErr", 256'(err), 256'(1));
    checkOutput("emptyBusy", 256'(busy), 256'(0));
    @(negedge clk);
    checkOutput("emptyErrPulse", 256'(err), 256'(0));
    checkOutput("emptyNoRead", 256'(reCount), 256'(0));
    checkOutput("emptySp", 256'(sp), 256'(16'hF000));

    $display("[TB] fill stack, overflow, simultaneous requests");
    for (int n = 1; n <= 16; n++) begin
      fcOut = mkFrame(n);
      applyStimulus(1'b1, 1'b0);
      waitDone(40, cyc);
      @(negedge clk);
    end
    checkOutput("fullSp", 256'(sp), 256'(16'hF0F0));
    wrBefore = wrAddrQ.size();
    applyStimulus(1'b1, 1'b0);
    checkOutput("fullErr", 256'(err), 256'(1));
    checkOutput("fullBusy", 256'(busy), 256'(0));
    @(negedge clk);
    checkOutput("fullSpHeld", 256'(sp), 256'(16'hF0F0));
    checkOutput("fullNoWrite", 256'(wrAddrQ.size()), 256'(wrBefore));
    applyStimulus(1'b0, 1'b1);
    waitDone(40, cyc);
    checkOutput("popFcIn", 256'(fcIn), 256'(mkFrame(16)));
    @(negedge clk);
    checkOutput("popSp", 256'(sp), 256'(16'hF0E1));
    fcOut = mkFrame(99);
    rdBefore = rdAddrQ.size();
    applyStimulus(1'b1, 1'b1);
    waitDone(40, cyc);
    checkOutput("bothIsCall", 256'(restore), 256'(0));
    @(negedge clk);
    checkOutput("bothSp", 256'(sp), 256'(16'hF0F0));
    checkOutput("bothNoRead", 256'(rdAddrQ.size()), 256'(rdBefore));
    checkOutput("bothMemFirst", 256'(mem[16'hF0E1]), 256'(16'h6301));
    checkOutput("bothMemLast", 256'(mem[16'hF0EF]), 256'(16'h630F));

    $display("[TB] call with random ack stalls");
    resetDut();
    for (int k = 0; k < 15; k++) mem[16'hF000 + k] = 16'h0;
    wrAddrQ.delete(); wrDataQ.delete();
    stallViol = 0;
    stallMode = 1'b1;
    fcOut = mkFrame(0);
    applyStimulus(1'b1, 1'b0);
    waitDone(400, cyc);
    stallMode = 1'b0;
    checkOutput("stallSp", 256'(sp), 256'(16'hF00F));
    checkOutput("stallWrCount", 256'(wrAddrQ.size()), 256'(15));
    checkOutput("stallHold", 256'(stallViol), 256'(0));
    for (int k = 0; k < 15; k++)
      checkOutput($sformatf("stallMem%0d", k), 256'(mem[16'hF000 + k]), 256'(k + 1));
    @(negedge clk);

    $display("[TB] reset during save");
    resetDut();
    wrAddrQ.delete(); wrDataQ.delete();
    fcOut = mkFrame(5);
    applyStimulus(1'b1, 1'b0);
    repeat (7) @(negedge clk);
    checkOutput("midSaveWrCount", 256'(wrAddrQ.size()), 256'(7));
    checkOutput("midSaveAddr", 256'(memAddr), 256'(16'hF007));
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", 256'(busy), 256'(0));
    checkOutput("abortMemWe", 256'(memWe), 256'(0));
    checkOutput("abortSp", 256'(sp), 256'(16'hF000));
    checkOutput("abortMemAddr", 256'(memAddr), 256'(0));
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abortRetErr", 256'(err), 256'(1));

    checkOutput("neverWeAndRe", 256'(bothCount), 256'(0));

    expFrame = '0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Hard bound on the whole run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
